// File: rtl/cpu_fetch_pkg.sv
// Shared fetch-stage types and vectors, also used by the PC register trigger logic.
package cpu_fetch_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] RESET_VECTOR = '0;
    localparam logic [XLEN-1:0] TRAP_VECTOR  = 32'h30;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Register-based synchronous FIFO with occupancy count and a synchronous clear.
module sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] data_in,
    input  logic             pop,
    output logic [WIDTH-1:0] data_out,
    output logic [CW-1:0]    count
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign push_ok  = push && (count != CW'(DEPTH));
    assign pop_ok   = pop && (count != '0);
    // Empty FIFO presents zero so the head never shows stale data.
    assign data_out = (count == '0) ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= AW'(wr_ptr + AW'(1));
            end
            if (pop_ok) begin
                rd_ptr <= AW'(rd_ptr + AW'(1));
            end
            count <= CW'(count + CW'(push_ok) - CW'(pop_ok));
        end
    end

endmodule

// File: rtl/fetch_buffer.sv
// Instruction fetch stage: credit-limited issue, in-order response tracking,
// instruction queue toward decode, and redirect discard of stale fetches.
module fetch_buffer
    import cpu_fetch_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] PC_i,
    output logic             pc_advance_o,
    input  logic             flush_i,
    output logic             imem_req_o,
    output logic [WIDTH-1:0] imem_addr_o,
    input  logic             imem_rvalid_i,
    input  logic [WIDTH-1:0] imem_rdata_i,
    output logic             instr_valid_o,
    output logic [WIDTH-1:0] instr_o,
    output logic [WIDTH-1:0] instr_pc_o,
    input  logic             instr_ready_i
);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned SW = CW + 1;
    localparam int unsigned EW = $bits(fetch_entry_t);

    logic [CW-1:0]    q_count;
    logic [CW-1:0]    inflight;
    logic [CW-1:0]    drop;
    logic [WIDTH-1:0] resp_pc;
    fetch_entry_t     q_in;
    fetch_entry_t     q_head;
    logic             q_push;
    logic             q_pop;
    logic             credit;

    // Registered occupancy only: a pop this cycle frees its slot next cycle.
    assign credit       = (SW'(inflight) + SW'(q_count)) < SW'(DEPTH);
    assign imem_req_o   = !rst && !flush_i && credit;
    assign pc_advance_o = imem_req_o;
    assign imem_addr_o  = PC_i;

    assign q_push        = imem_rvalid_i && (drop == '0) && !flush_i;
    assign instr_valid_o = (q_count != '0);
    assign q_pop         = instr_valid_o && instr_ready_i && !flush_i;

    assign q_in       = '{instr: XLEN'(imem_rdata_i), pc: XLEN'(resp_pc)};
    assign instr_o    = WIDTH'(q_head.instr);
    assign instr_pc_o = WIDTH'(q_head.pc);

    sync_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk      (clk),
        .rst      (rst),
        .clear    (flush_i),
        .push     (q_push),
        .data_in  (q_in),
        .pop      (q_pop),
        .data_out (q_head),
        .count    (q_count)
    );

    // Issued PCs wait here for their responses; occupancy is the in-flight count.
    sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_inflight (
        .clk      (clk),
        .rst      (rst),
        .clear    (1'b0),
        .push     (imem_req_o),
        .data_in  (PC_i),
        .pop      (imem_rvalid_i),
        .data_out (resp_pc),
        .count    (inflight)
    );

    // Responses older than a redirect arrive first and are discarded by count.
    always_ff @(posedge clk) begin
        if (rst) begin
            drop <= '0;
        end else if (flush_i) begin
            drop <= CW'(inflight - CW'(imem_rvalid_i));
        end else if (imem_rvalid_i && (drop != '0)) begin
            drop <= CW'(drop - CW'(1));
        end
    end

endmodule
